// File: rtl/cnn_layer_sequencer.sv
// Layer scheduler for the CNN accelerator: walks the descriptor ROM and drives one engine per layer.
// Optional build macro SEQ_WATCHDOG_EN adds a RUN-state watchdog (err_code 3).
module cnn_layer_sequencer #(
  parameter int                DATA_W    = 16,
  parameter int                IDX_W     = 3,
  parameter logic [DATA_W-1:0] BUF0_BASE = 16'h4000,
  parameter logic [DATA_W-1:0] BUF1_BASE = 16'h8000,
  parameter int                WDOG_CYC  = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] img_base,
  input  logic [DATA_W-1:0] img_size,
  input  logic [DATA_W-1:0] img_count,
  output logic [IDX_W-1:0]  desc_addr,
  input  logic [15:0]       desc_data,
  output logic [2:0]        eng_en,
  input  logic [2:0]        eng_done,
  output logic [DATA_W-1:0] in_addr,
  output logic [DATA_W-1:0] out_addr,
  output logic [DATA_W-1:0] in_size,
  output logic [DATA_W-1:0] in_count,
  output logic [3:0]        win,
  output logic [7:0]        out_maps,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [IDX_W-1:0]  layer_idx
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_DECODE  = 3'd2;
  localparam logic [2:0] S_RUN     = 3'd3;
  localparam logic [2:0] S_ADVANCE = 3'd4;
  localparam logic [2:0] S_FIN     = 3'd5;
  localparam logic [2:0] S_ERR     = 3'd6;

  localparam logic [1:0] T_END  = 2'd0;
  localparam logic [1:0] T_CONV = 2'd1;
  localparam logic [1:0] T_POOL = 2'd2;
  localparam logic [1:0] T_FC   = 2'd3;

  localparam logic [1:0] E_GEOM = 2'd1;
  localparam logic [1:0] E_NOEND = 2'd2;
  localparam logic [1:0] E_WDOG = 2'd3;

  logic [2:0] state;
  logic [1:0] layType;

  logic [1:0]        descType;
  logic [7:0]        descMaps;
  logic [3:0]        descWin;
  logic [DATA_W-1:0] descWinExt;
  logic [DATA_W-1:0] winExt;
  logic [DATA_W-1:0] mapsExt;
  logic [DATA_W-1:0] nextSize;
  logic [DATA_W-1:0] nextCount;
  logic [2:0]        descSel;
  logic              badGeom;
  logic              selDone;

  assign descType   = desc_data[15:14];
  assign descMaps   = desc_data[13:6];
  assign descWin    = desc_data[5:2];
  assign descWinExt = DATA_W'(descWin);
  assign winExt     = DATA_W'(win);
  assign mapsExt    = DATA_W'(out_maps);

  wire unusedBits = &{1'b0, desc_data[1:0]};

  // The ROM is addressed only while fetching; the index is held in layer_idx otherwise.
  assign desc_addr = (state == S_FETCH) ? layer_idx : '0;

  assign badGeom = ((descType == T_CONV) || (descType == T_POOL)) &&
                   ((descWin == 4'd0) || (descWinExt > in_size));

  assign selDone = |(eng_done & eng_en);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    descSel = 3'b000;
    case (descType)
      T_CONV:  descSel = 3'b001;
      T_POOL:  descSel = 3'b010;
      T_FC:    descSel = 3'b100;
      default: descSel = 3'b000;
    endcase
  end

  // Geometry of the next layer's input, derived from the layer that just finished.
  always_comb begin
    nextSize  = in_size;
    nextCount = in_count;
    case (layType)
      T_CONV: begin
        nextSize  = in_size - winExt + DATA_W'(1);
        nextCount = mapsExt;
      end
      T_POOL: begin
        nextSize  = in_size / winExt;
      end
      T_FC: begin
        nextSize  = DATA_W'(1);
        nextCount = mapsExt;
      end
      default: ;
    endcase
  end

`ifdef SEQ_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYC + 1);
  logic [WDOG_W-1:0] wdogCnt;
  logic              wdogHit;
  assign wdogHit = (wdogCnt == WDOG_W'(WDOG_CYC - 1));
`else
  wire unusedWdog = (WDOG_CYC == 0);
`endif

  // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      layType   <= T_END;
      eng_en    <= '0;
      in_addr   <= '0;
      out_addr  <= '0;
      in_size   <= '0;
      in_count  <= '0;
      win       <= '0;
      out_maps  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      err_code  <= '0;
      layer_idx <= '0;
`ifdef SEQ_WATCHDOG_EN
      wdogCnt   <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            in_addr   <= img_base;
            out_addr  <= BUF0_BASE;
            in_size   <= img_size;
            in_count  <= img_count;
            layer_idx <= '0;
            error     <= 1'b0;
            err_code  <= '0;
            busy      <= 1'b1;
            state     <= S_FETCH;
          end
        end

        S_FETCH: state <= S_DECODE;

        S_DECODE: begin
          if (descType == T_END) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_FIN;
          end else if (badGeom) begin
            eng_en   <= '0;
            busy     <= 1'b0;
            error    <= 1'b1;
            err_code <= E_GEOM;
            state    <= S_ERR;
          end else begin
            win      <= descWin;
            out_maps <= descMaps;
            layType  <= descType;
            eng_en   <= descSel;
`ifdef SEQ_WATCHDOG_EN
            wdogCnt  <= '0;
`endif
            state    <= S_RUN;
          end
        end

        S_RUN: begin
          if (selDone) begin
            eng_en <= '0;
            state  <= S_ADVANCE;
          end
`ifdef SEQ_WATCHDOG_EN
          else if (wdogHit) begin
            eng_en   <= '0;
            busy     <= 1'b0;
            error    <= 1'b1;
            err_code <= E_WDOG;
            state    <= S_ERR;
          end else begin
            wdogCnt <= wdogCnt + WDOG_W'(1);
          end
`endif
        end

        S_ADVANCE: begin
          in_addr   <= out_addr;
          out_addr  <= (out_addr == BUF0_BASE) ? BUF1_BASE : BUF0_BASE;
          in_size   <= nextSize;
          in_count  <= nextCount;
          layer_idx <= layer_idx + IDX_W'(1);
          if (layer_idx == '1) begin
            busy     <= 1'b0;
            error    <= 1'b1;
            err_code <= E_NOEND;
            state    <= S_ERR;
          end else begin
            state <= S_FETCH;
          end
        end

        S_FIN:   state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Scoreboard bench for cnn_layer_sequencer: expected engine starts, done and error events are queued
// by the stimulus and popped by an independent monitor.
module tb_cnn_layer_sequencer;

  localparam int WDOG = 100;
  localparam int KIND_ENG  = 0;
  localparam int KIND_DONE = 1;
  localparam int KIND_ERR  = 2;
  // Edges from the start-sampling edge (or the engine-done edge) to eng_en being visible.
  localparam int START_TO_EN = 3;
  localparam int DONE_TO_EN  = 4;

  localparam logic [1:0] T_END  = 2'd0;
  localparam logic [1:0] T_CONV = 2'd1;
  localparam logic [1:0] T_POOL = 2'd2;
  localparam logic [1:0] T_FC   = 2'd3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] img_base = '0;
  logic [15:0] img_size = '0;
  logic [15:0] img_count = '0;
  logic [2:0]  desc_addr;
  logic [15:0] desc_data = '0;
  logic [2:0]  eng_en;
  logic [2:0]  eng_done = '0;
  logic [15:0] in_addr, out_addr, in_size, in_count;
  logic [3:0]  win;
  logic [7:0]  out_maps;
  logic        busy, done, error;
  logic [1:0]  err_code;
  logic [2:0]  layer_idx;

  cnn_layer_sequencer #(.WDOG_CYC(WDOG)) dut (
    .clk(clk), .reset(reset), .start(start),
    .img_base(img_base), .img_size(img_size), .img_count(img_count),
    .desc_addr(desc_addr), .desc_data(desc_data),
    .eng_en(eng_en), .eng_done(eng_done),
    .in_addr(in_addr), .out_addr(out_addr), .in_size(in_size), .in_count(in_count),
    .win(win), .out_maps(out_maps),
    .busy(busy), .done(done), .error(error), .err_code(err_code), .layer_idx(layer_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // NOTE: the descriptor ROM is a plain memory with no reset; contents are loaded by the stimulus.
  logic [15:0] rom [0:7];
  always @(posedge clk) desc_data <= rom[desc_addr];

  typedef struct {
    int          kind;
    logic [2:0]  en;
    logic [15:0] inAddr, outAddr, inSize, inCount;
    logic [3:0]  win;
    logic [7:0]  maps;
    logic [2:0]  idx;
    logic [1:0]  code;
    int          lat;
  } ev_t;

  ev_t sbq[$];
  int checks = 0;
  int errors = 0;

  int startCyc = 0;
  int doneCyc = 0;
  bit firstAfterStart = 1'b0;
  int engDelay = 0;
  bit spurious = 1'b0;
  bit withholdDone = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mkDesc(input logic [1:0] t, input logic [7:0] m, input logic [3:0] w);
    return {t, m, w, 2'b00};
  endfunction

  task automatic pushEng(input logic [2:0] en, input logic [15:0] ia, input logic [15:0] oa,
                         input logic [15:0] sz, input logic [15:0] ct, input logic [3:0] w,
                         input logic [7:0] m, input logic [2:0] idx);
    ev_t e;
    e = '{kind: KIND_ENG, en: en, inAddr: ia, outAddr: oa, inSize: sz, inCount: ct,
          win: w, maps: m, idx: idx, code: 2'd0, lat: -1};
    sbq.push_back(e);
  endtask

  task automatic pushDone(input logic [15:0] oa, input logic [15:0] sz, input logic [15:0] ct);
    ev_t e;
    e = '{kind: KIND_DONE, en: 3'd0, inAddr: 16'd0, outAddr: oa, inSize: sz, inCount: ct,
          win: 4'd0, maps: 8'd0, idx: 3'd0, code: 2'd0, lat: -1};
    sbq.push_back(e);
  endtask

  task automatic pushErr(input logic [1:0] code, input int lat);
    ev_t e;
    e = '{kind: KIND_ERR, en: 3'd0, inAddr: 16'd0, outAddr: 16'd0, inSize: 16'd0, inCount: 16'd0,
          win: 4'd0, maps: 8'd0, idx: 3'd0, code: code, lat: lat};
    sbq.push_back(e);
  endtask

  // Engine model: reacts half a cycle after eng_en rises, optionally pulsing non-selected done bits first.
  initial begin
    int engCnt;
    logic [2:0] prevEn;
    engCnt = -1;
    prevEn = '0;
    forever begin
      @(negedge clk);
      #1;
      eng_done = '0;
      if (eng_en == 3'b000) begin
        engCnt = -1;
      end else begin
        if (prevEn == 3'b000) engCnt = engDelay;
        if (!withholdDone) begin
          if (engCnt == 0) begin
            eng_done = eng_en;
            doneCyc = cyc;
            engCnt = -1;
          end else if (engCnt > 0) begin
            if (spurious) eng_done = ~eng_en;
            engCnt--;
          end
        end
      end
      prevEn = eng_en;
    end
  end

  // Monitor: pops one expected event whenever the DUT starts an engine, finishes or flags an error.
  initial begin
    ev_t e;
    logic [2:0] mPrevEn;
    logic mPrevErr;
    logic [78:0] snap;
    int runEntryCyc;
    mPrevEn = '0;
    mPrevErr = 1'b0;
    snap = '0;
    runEntryCyc = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        mPrevEn = '0;
        mPrevErr = 1'b0;
      end else begin
        if (eng_en != 3'b000 && mPrevEn == 3'b000) begin
          runEntryCyc = cyc;
          if (sbq.size() == 0) begin
            check("unexpected_eng_en", {29'd0, eng_en}, 32'd0);
          end else begin
            e = sbq.pop_front();
            check("ev_kind_eng", KIND_ENG, e.kind);
            check("eng_en", {29'd0, eng_en}, {29'd0, e.en});
            check("in_addr", {16'd0, in_addr}, {16'd0, e.inAddr});
            check("out_addr", {16'd0, out_addr}, {16'd0, e.outAddr});
            check("in_size", {16'd0, in_size}, {16'd0, e.inSize});
            check("in_count", {16'd0, in_count}, {16'd0, e.inCount});
            check("win", {28'd0, win}, {28'd0, e.win});
            check("out_maps", {24'd0, out_maps}, {24'd0, e.maps});
            check("layer_idx", {29'd0, layer_idx}, {29'd0, e.idx});
            if (firstAfterStart) begin
              check("lat_start_to_en", cyc - startCyc, START_TO_EN);
              firstAfterStart = 1'b0;
            end else begin
              check("lat_done_to_en", cyc - doneCyc, DONE_TO_EN);
            end
          end
          snap = {in_addr, out_addr, in_size, in_count, win, out_maps, layer_idx};
        end else if (eng_en != 3'b000 && eng_en == mPrevEn) begin
          check("run_operands_held",
                {31'd0, snap != {in_addr, out_addr, in_size, in_count, win, out_maps, layer_idx}}, 32'd0);
        end
        if (done) begin
          if (sbq.size() == 0) begin
            check("unexpected_done", {31'd0, done}, 32'd0);
          end else begin
            e = sbq.pop_front();
            check("ev_kind_done", KIND_DONE, e.kind);
            check("fin_out_addr", {16'd0, out_addr}, {16'd0, e.outAddr});
            check("fin_size", {16'd0, in_size}, {16'd0, e.inSize});
            check("fin_count", {16'd0, in_count}, {16'd0, e.inCount});
            check("fin_busy", {31'd0, busy}, 32'd0);
          end
        end
        if (error && !mPrevErr) begin
          if (sbq.size() == 0) begin
            check("unexpected_error", {30'd0, err_code}, 32'd0);
          end else begin
            e = sbq.pop_front();
            check("ev_kind_err", KIND_ERR, e.kind);
            check("err_code", {30'd0, err_code}, {30'd0, e.code});
            check("err_eng_en", {29'd0, eng_en}, 32'd0);
            check("err_busy", {31'd0, busy}, 32'd0);
            if (e.lat >= 0) check("wdog_latency", cyc - runEntryCyc, e.lat);
          end
        end
        mPrevEn = eng_en;
        mPrevErr = error;
      end
    end
  end

  task automatic clearRom();
    for (int i = 0; i < 8; i++) rom[i] = mkDesc(T_END, 8'd0, 4'd0);
  endtask

  task automatic doStart(input logic [15:0] b, input logic [15:0] s, input logic [15:0] c);
    @(negedge clk);
    img_base = b;
    img_size = s;
    img_count = c;
    start = 1'b1;
    startCyc = cyc;
    firstAfterStart = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", {31'd0, busy}, 32'd1);
    check("start_clears_error", {31'd0, error}, 32'd0);
  endtask

  task automatic waitDrain(input string name, input int limit);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check({"drain_", name}, sbq.size(), 32'd0);
    sbq.delete();
    repeat (3) @(negedge clk);
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, "_desc_addr"}, {29'd0, desc_addr}, 32'd0);
    check({tag, "_eng_en"}, {29'd0, eng_en}, 32'd0);
    check({tag, "_addrs"}, {in_addr, out_addr}, 32'd0);
    check({tag, "_geom"}, {in_size, in_count}, 32'd0);
    check({tag, "_win_maps"}, {20'd0, win, out_maps}, 32'd0);
    check({tag, "_flags"}, {26'd0, busy, done, error, err_code, 1'b0}, 32'd0);
    check({tag, "_layer_idx"}, {29'd0, layer_idx}, 32'd0);
  endtask

  task automatic loadT1();
    clearRom();
    rom[0] = mkDesc(T_CONV, 8'd4, 4'd3);
    rom[1] = mkDesc(T_POOL, 8'd0, 4'd2);
  endtask

  task automatic expectT1();
    pushEng(3'b001, 16'h0000, 16'h4000, 16'd32, 16'd1, 4'd3, 8'd4, 3'd0);
    pushEng(3'b010, 16'h4000, 16'h8000, 16'd30, 16'd4, 4'd2, 8'd0, 3'd1);
    pushDone(16'h4000, 16'd15, 16'd4);
  endtask

  initial begin
    clearRom();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // T1: CONV then POOL, engine answers in the RUN entry cycle.
    engDelay = 0;
    loadT1();
    expectT1();
    doStart(16'h0000, 16'd32, 16'd1);
    waitDrain("t1", 300);

    // T2: POOL, POOL, FC with stray done bits and a start while busy.
    engDelay = 2;
    spurious = 1'b1;
    clearRom();
    rom[0] = mkDesc(T_POOL, 8'd0, 4'd2);
    rom[1] = mkDesc(T_POOL, 8'd0, 4'd2);
    rom[2] = mkDesc(T_FC, 8'd10, 4'd0);
    pushEng(3'b010, 16'h1000, 16'h4000, 16'd8, 16'd3, 4'd2, 8'd0, 3'd0);
    pushEng(3'b010, 16'h4000, 16'h8000, 16'd4, 16'd3, 4'd2, 8'd0, 3'd1);
    pushEng(3'b100, 16'h8000, 16'h4000, 16'd2, 16'd3, 4'd0, 8'd10, 3'd2);
    pushDone(16'h8000, 16'd1, 16'd10);
    doStart(16'h1000, 16'd8, 16'd3);
    repeat (6) @(negedge clk);
    img_base = 16'hDEAD;
    img_size = 16'd99;
    img_count = 16'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDrain("t2", 300);
    spurious = 1'b0;

    // T3: window larger than the map.
    clearRom();
    rom[0] = mkDesc(T_CONV, 8'd1, 4'd5);
    pushErr(2'd1, -1);
    doStart(16'h0000, 16'd4, 16'd1);
    waitDrain("t3", 100);

    // T4: eight POOL win=1 layers and no END.
    engDelay = 1;
    for (int i = 0; i < 8; i++) rom[i] = mkDesc(T_POOL, 8'd0, 4'd1);
    pushEng(3'b010, 16'h0200, 16'h4000, 16'd5, 16'd2, 4'd1, 8'd0, 3'd0);
    for (int i = 1; i < 8; i++)
      pushEng(3'b010, (i % 2 == 1) ? 16'h4000 : 16'h8000, (i % 2 == 1) ? 16'h8000 : 16'h4000,
              16'd5, 16'd2, 4'd1, 8'd0, 3'(i));
    pushErr(2'd2, -1);
    doStart(16'h0200, 16'd5, 16'd2);
    waitDrain("t4", 500);

    // T5: reset in the middle of RUN, then a clean T1.
    engDelay = 6;
    loadT1();
    pushEng(3'b001, 16'h0000, 16'h4000, 16'd32, 16'd1, 4'd3, 8'd4, 3'd0);
    doStart(16'h0000, 16'd32, 16'd1);
    for (int n = 0; n < 20 && eng_en == 3'b000; n++) @(negedge clk);
    check("t5_in_run", {31'd0, eng_en != 3'b000}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkAllZero("midrun_reset");
    reset = 1'b0;
    sbq.delete();
    repeat (2) @(negedge clk);
    engDelay = 1;
    expectT1();
    doStart(16'h0000, 16'd32, 16'd1);
    waitDrain("t5", 300);

`ifdef SEQ_WATCHDOG_EN
    // T6: engine never answers.
    withholdDone = 1'b1;
    clearRom();
    rom[0] = mkDesc(T_CONV, 8'd1, 4'd1);
    pushEng(3'b001, 16'h0000, 16'h4000, 16'd4, 16'd1, 4'd1, 8'd1, 3'd0);
    pushErr(2'd3, WDOG);
    doStart(16'h0000, 16'd4, 16'd1);
    waitDrain("t6", 400);
    withholdDone = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not reach its end, required completion");
    $fatal(1, "global timeout");
  end

endmodule
